fusion_unit_acc: RTL
====================

// Module: fusion_unit_acc
// PURPOSE
//  Parametrised, pipelined successor of the 4x4 bitbrick fusion unit. Fuses 16 2-bit bitbricks into a
//  dot product of 1..16 lanes at runtime precision (2/4/8 bit per operand, signed/unsigned). Shift
//  amounts are generated internally from the mode; no external shift vector is needed.
//  Accumulates cfg_len input beats (plus an optional partial sum) per group and returns one result
//  over a valid/ready handshake. Sits between the systolic input buffers and the output/psum buffer.
// PARAMETERS
//  PSUM_W  20  width of in_psum, sign-extended into the accumulator
//  ACC_W   24  accumulator/out_sum width, two's complement; must be >= PSUM_W
//  CNT_W   8   width of cfg_len and the beat counter
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  cfg_we     in   1       load config (honoured only when busy==0)
//  cfg_mode_x in   2       x precision: 00=2b, 01=4b, 10=8b, 11=illegal
//  cfg_mode_y in   2       y precision, same encoding
//  cfg_sign_x in   1       1 = x lanes signed
//  cfg_sign_y in   1       1 = y lanes signed
//  cfg_len    in   CNT_W   beats per accumulation group (0 is treated as 1)
//  cfg_err    out  1       1-cycle pulse: cfg_we while busy, or illegal mode; config unchanged
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted when in_valid&&in_ready
//  in_x       in   32      packed x lanes; lane k = in_x[k*wx +: wx]
//  in_y       in   32      packed y lanes; lane k = in_y[k*wy +: wy]
//  in_psum    in   PSUM_W  partial sum; used only on the first beat of a group
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       downstream accepts result
//  out_sum    out  ACC_W   accumulated group result
//  out_ovf    out  1       signed overflow occurred in this group (qualified by out_valid)
//  busy       out  1       any beat in flight, a group partially accumulated, or out_valid high
// BEHAVIOUR
//  - Reset (async, reset==0): FSM=IDLE; all pipe valids, counter, accumulator and out regs cleared;
//    in_ready=0, out_valid=0, out_sum=0, out_ovf=0, cfg_err=0, busy=0. Mid-group data is discarded.
//  - FSM: IDLE --cfg_we (legal)--> RUN. RUN --cfg_we (legal, busy==0)--> RUN with the new config.
//    An illegal mode keeps the FSM in IDLE or keeps the old config, and pulses cfg_err.
//  - Lanes: wx,wy in {2,4,8}; P = 16/((wx/2)*(wy/2)) lanes. Each brick gets a 2-bit slice.
//    Only the MSB slice of a lane carries the sign flag. Brick shift = 2*(slice index in x + slice index in y).
//  - Beat sum = sum over k<P of x_k*y_k. Bits of in_x/in_y beyond P lanes are ignored.
//  - Pipeline: S1 registers 16 brick products. S2 registers the shifted adder-tree sum (sign-extended to ACC_W).
//    S3 is the accumulator. Each stage carries first/last tags.
//  - First beat: acc <= psum_sext + beat_sum. Other beats: acc <= acc + beat_sum.
//  - Beat counter 0..max(cfg_len,1)-1, wraps to 0 after the last beat.
//  - On last beat in S3: out_sum <= final acc, out_ovf <= sticky group overflow, out_valid <= 1.
//    Latency: last beat accepted at cycle t gives out_valid at t+3 when there is no stall.
//  - Stall: en = !(out_valid && !out_ready). All stages hold when en==0; in_ready = en && state==RUN.
//    Back-to-back groups run with no bubble when out_ready==1.
//  - Overflow: accumulator wraps modulo 2^ACC_W; ovf set on signed add overflow, cleared at group start.
//  - out_valid && out_ready in the same cycle as a new last beat in S3: the new result loads with no gap.
//  - cfg_len==1: every beat is both first and last.
// TESTING
//  1 8x8 signed, len=1, in_x=0xFF, in_y=0x80, in_psum=5 -> out_sum=133 at accept+3, out_ovf=0
//  2 2x2 unsigned, len=4, in_x=in_y=0xFFFFFFFF x4 beats -> 144 per beat, out_sum=576
//  3 4x4 signed, in_x=in_y=0x00008888, len=1 -> 4 lanes of (-8)*(-8) -> out_sum=256
//  4 case 3 repeated 3 groups with out_ready=0 for 5 cycles -> in_ready=0 while stalled, 3 results in order, none lost
//  5 ACC_W=16, 8x8 unsigned 0xFF*0xFF, len=2 -> out_sum=130050 mod 65536 = 64514, out_ovf=1
//  6 cfg_we mid-group -> cfg_err pulse, old mode kept; reset=0 mid-group -> all outputs 0, FSM=IDLE

Source files
------------

// File: rtl/fusion_unit_acc.sv
// Bitbrick fusion dot-product unit with group accumulator.
// 16 2-bit bricks are fused into 1..16 lanes. Operand precision and signedness
// are set at runtime. Beats are accumulated into one result per group.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no legal configuration loaded yet; input not accepted
// ST_RUN   | configured; beats accepted while the pipeline is not stalled
module fusion_unit_acc #(
  parameter int PSUM_W = 20,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode_x,
  input  logic [1:0]        cfg_mode_y,
  input  logic              cfg_sign_x,
  input  logic              cfg_sign_y,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x,
  input  logic [31:0]       in_y,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  // A single beat sum is at most 2 * 255 * 255, or -2 * 255 * 128; 20 bits holds it.
  localparam int BEAT_W = 20;
  // The accumulate add runs one bit wider than both operands so overflow of the
  // ACC_W result can be judged from the true sum even when ACC_W < BEAT_W.
  localparam int SUM_W  = (ACC_W > BEAT_W) ? ACC_W : BEAT_W;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_mode_x, r_mode_y;
  logic               r_sign_x, r_sign_y;
  logic [CNT_W-1:0]   r_len_m1;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;

  logic               r_s1_vld, r_s1_first, r_s1_last;
  logic [PSUM_W-1:0]  r_s1_psum;
  logic signed [5:0]  r_prod [16];

  logic               r_s2_vld, r_s2_first, r_s2_last;
  logic [PSUM_W-1:0]  r_s2_psum;
  logic signed [SUM_W-1:0] r_s2_sum;

  logic signed [ACC_W-1:0] r_acc;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;

  logic               w_en, w_in_fire, w_busy, w_first, w_last;
  logic               w_mode_bad, w_cfg_load, w_cfg_err;
  logic [2:0]         w_lp;
  logic [3:0]         w_mask_p;
  logic [1:0]         w_mask_x;
  logic signed [5:0]  w_prod [16];
  logic [3:0]         w_sh [16];
  logic signed [BEAT_W-1:0] w_tree;
  logic signed [SUM_W:0]    w_base, w_sum;
  logic [SUM_W-ACC_W+1:0]   w_top;
  logic               w_ovf, w_grp_ovf;

  assign w_en      = !(r_out_valid && !out_ready);
  assign in_ready  = w_en && (r_state == ST_RUN);
  assign w_in_fire = in_valid && in_ready;
  assign w_busy    = r_s1_vld || r_s2_vld || (r_cnt != '0) || r_out_valid;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == r_len_m1);
  assign w_mode_bad = (cfg_mode_x == 2'b11) || (cfg_mode_y == 2'b11);

  assign busy      = w_busy;
  assign cfg_err   = r_cfg_err;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

  // Next-state and config acceptance; a beat landing this cycle counts as busy.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_load  = 1'b0;
    w_cfg_err   = 1'b0;
    if (cfg_we) begin
      if (w_mode_bad || w_busy || w_in_fire) begin
        w_cfg_err = 1'b1;
      end else begin
        w_cfg_load  = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // State register, configuration and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_mode_x  <= '0;
      r_mode_y  <= '0;
      r_sign_x  <= 1'b0;
      r_sign_y  <= 1'b0;
      r_len_m1  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_err;
      if (w_cfg_load) begin
        r_mode_x <= cfg_mode_x;
        r_mode_y <= cfg_mode_y;
        r_sign_x <= cfg_sign_x;
        r_sign_y <= cfg_sign_y;
        r_len_m1 <= (cfg_len == '0) ? '0 : cfg_len - 1'b1;
      end
    end
  end

  // Beat counter within a group; wraps after the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Lane geometry: nx = 2^mode_x slices per x lane, ny = 2^mode_y per y lane.
  assign w_lp     = {1'b0, r_mode_x} + {1'b0, r_mode_y};
  assign w_mask_p = 4'((5'd1 << w_lp) - 5'd1);
  assign w_mask_x = 2'((3'd1 << r_mode_x) - 3'd1);

  for (genvar g = 0; g < 16; g++) begin : g_brick
    logic [3:0]        w_k, w_j;
    logic [1:0]        w_i, w_s;
    logic [5:0]        w_ix, w_iy;
    logic [1:0]        w_xs, w_ys;
    logic              w_xm, w_ym;
    logic signed [2:0] w_xo, w_yo;

    // Brick g belongs to lane k and covers x slice i, y slice s of that lane.
    assign w_k  = 4'(g) >> w_lp;
    assign w_j  = 4'(g) & w_mask_p;
    assign w_i  = w_j[1:0] & w_mask_x;
    assign w_s  = 2'(w_j >> r_mode_x);
    assign w_ix = ({2'b0, w_k} << ({1'b0, r_mode_x} + 3'd1)) + {3'b0, w_i, 1'b0};
    assign w_iy = ({2'b0, w_k} << ({1'b0, r_mode_y} + 3'd1)) + {3'b0, w_s, 1'b0};
    assign w_xs = 2'(in_x >> w_ix);
    assign w_ys = 2'(in_y >> w_iy);
    // Only the top slice of a signed lane is sign-extended.
    assign w_xm = r_sign_x && (w_i == w_mask_x);
    assign w_ym = r_sign_y && ({2'b0, w_s} == 4'((w_mask_p >> r_mode_x)));
    assign w_xo = {w_xm & w_xs[1], w_xs};
    assign w_yo = {w_ym & w_ys[1], w_ys};
    assign w_prod[g] = w_xo * w_yo;
    assign w_sh[g]   = {({1'b0, w_i} + {1'b0, w_s}), 1'b0};
  end

  // Shifted adder tree over the registered brick products.
  always_comb begin
    w_tree = '0;
    for (int g = 0; g < 16; g++) begin
      w_tree = w_tree + (BEAT_W'(r_prod[g]) <<< w_sh[g]);
    end
  end

  // S1: brick products plus group tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_psum  <= '0;
      for (int g = 0; g < 16; g++) r_prod[g] <= '0;
    end else if (w_en) begin
      r_s1_vld <= w_in_fire;
      if (w_in_fire) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_psum  <= in_psum;
        r_prod     <= w_prod;
      end
    end
  end

  // S2: beat sum, sign-extended to the accumulate width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_psum  <= '0;
      r_s2_sum   <= '0;
    end else if (w_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_psum  <= r_s1_psum;
        r_s2_sum   <= SUM_W'(w_tree);
      end
    end
  end

  assign w_base    = r_s2_first ? (SUM_W+1)'($signed(r_s2_psum)) : (SUM_W+1)'(r_acc);
  assign w_sum     = w_base + (SUM_W+1)'(r_s2_sum);
  assign w_top     = w_sum[SUM_W:ACC_W-1];
  assign w_ovf     = !((&w_top) || !(|w_top));
  assign w_grp_ovf = w_ovf || (!r_s2_first && r_ovf);

  // S3: accumulator with sticky group overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_en && r_s2_vld) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= w_grp_ovf;
    end
  end

  // Result register; a new result may replace one being consumed this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en && r_s2_vld && r_s2_last) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum[ACC_W-1:0];
      r_out_ovf   <= w_grp_ovf;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
